// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the 8-entry x 64-bit FIFO (fifo8x64) and its
// head-select mux (mux81).
//   FIFO_DEPTH / FIFO_WIDTH : storage geometry (8 x 64)
//   FIFO_PTR_W              : read/write pointer width (3 bits, wraps 7 -> 0)
//   FIFO_CNT_W              : occupancy counter width (4 bits, 0..8)
//   fifo_op_e               : per-cycle operation {push, pop}
//   ptr_next()              : pointer increment with natural wrap
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_WIDTH = 64;
    localparam int FIFO_PTR_W = 3;
    localparam int FIFO_CNT_W = 4;

    // Encoding is {push, pop} so the top can build it by concatenation.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

    // Pointer width equals log2(depth), so the 3-bit add wraps 7 -> 0 for free.
    function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] ptr);
        return ptr + 3'd1;
    endfunction

endpackage

// File: rtl/fifo8x64_mux81.sv
// -----------------------------------------------------------------------------
// mux81
// 8:1 keyed selector. Returns data[key]; any key outside 0..7 returns
// default_data (unreachable with a 3-bit key, kept as a safe fallback).
// Ports:
//   key          in  [2:0]      entry select
//   data         in  [7:0][W-1] candidate words
//   default_data in  [W-1:0]    value for an unmatched key
//   sel_data     out [W-1:0]    selected word (combinational)
// -----------------------------------------------------------------------------
module mux81
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) (
    input  logic [FIFO_PTR_W-1:0] key,
    input  logic [7:0][W-1:0]     data,
    input  logic [W-1:0]          default_data,
    output logic [W-1:0]          sel_data
);

    // Key-driven word select.
    always_comb begin
        sel_data = default_data;
        case (key)
            3'd0:    sel_data = data[0];
            3'd1:    sel_data = data[1];
            3'd2:    sel_data = data[2];
            3'd3:    sel_data = data[3];
            3'd4:    sel_data = data[4];
            3'd5:    sel_data = data[5];
            3'd6:    sel_data = data[6];
            3'd7:    sel_data = data[7];
            default: sel_data = default_data;
        endcase
    end

endmodule

// File: rtl/fifo8x64.sv
// -----------------------------------------------------------------------------
// fifo8x64
// 8-entry x 64-bit synchronous first-word-fall-through FIFO with valid/ready
// handshakes on both sides, synchronous flush and synchronous active-high reset.
//
// Optional feature (compile-time macro FIFO8X64_BYPASS_EN):
//   When defined, an empty FIFO forwards in_data straight to out_data in the
//   same cycle. If the consumer takes it, nothing is stored; otherwise it is
//   written as an ordinary push. When undefined, out_valid depends on
//   registered state only and a word into an empty FIFO shows up one cycle
//   after the push.
//
// Ports:
//   clk        in        single clock, rising edge
//   rst        in        synchronous active-high reset (overrides everything)
//   flush      in        synchronous clear of all entries (beats push/pop)
//   in_valid   in        producer offers in_data
//   in_ready   out       FIFO accepts a push this cycle (not full)
//   in_data    in  [63:0] push data
//   out_valid  out       out_data holds the head entry
//   out_ready  in        consumer takes the head this cycle
//   out_data   out [63:0] head entry, 0 while out_valid is 0
//   count      out [3:0] occupancy 0..8
// -----------------------------------------------------------------------------
module fifo8x64
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam logic [FIFO_CNT_W-1:0] CNT_FULL  = FIFO_CNT_W'(DEPTH);
    localparam logic [FIFO_CNT_W-1:0] CNT_EMPTY = 4'd0;

    // Storage is deliberately not reset: out_data masking hides stale words.
    logic [DEPTH-1:0][WIDTH-1:0] mem_r;
    logic [FIFO_PTR_W-1:0]       wr_ptr_r;
    logic [FIFO_PTR_W-1:0]       rd_ptr_r;
    logic [FIFO_CNT_W-1:0]       count_r;

    logic                        empty_s;
    logic                        full_s;
    logic                        bypass_s;
    logic                        push_s;
    logic                        pop_s;
    fifo_op_e                    op_s;
    logic [WIDTH-1:0]            head_data_s;

    // Head-of-queue select, keyed by the read pointer.
    mux81 #(
        .W (WIDTH)
    ) u_head_mux (
        .key          (rd_ptr_r),
        .data         (mem_r),
        .default_data ({WIDTH{1'b0}}),
        .sel_data     (head_data_s)
    );

    // Status flags and handshake qualification.
    always_comb begin
        empty_s  = (count_r == CNT_EMPTY);
        full_s   = (count_r == CNT_FULL);
`ifdef FIFO8X64_BYPASS_EN
        bypass_s = empty_s & in_valid;
`else
        bypass_s = 1'b0;
`endif
        in_ready  = ~full_s;
        out_valid = ~empty_s | bypass_s;
        // A pop only ever comes from stored data; a bypassed word that the
        // consumer takes is neither stored nor popped.
        pop_s  = ~empty_s & out_ready;
        // in_ready looks at registered count only, so a full FIFO refuses
        // the push even when a pop frees a slot in the same cycle.
        push_s = in_valid & ~full_s & ~(bypass_s & out_ready);
        op_s   = fifo_op_e'({push_s, pop_s});
    end

    // Output data: bypassed word, stored head, or zero when nothing is valid.
    always_comb begin
        out_data = {WIDTH{1'b0}};
        if (bypass_s) begin
            out_data = in_data;
        end else if (!empty_s) begin
            out_data = head_data_s;
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    assign count = count_r;

    // Pointer and occupancy registers; rst outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else if (flush) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else begin
            case (op_s)
                FIFO_OP_PUSH: begin
                    wr_ptr_r <= ptr_next(wr_ptr_r);
                    count_r  <= count_r + 4'd1;
                end
                FIFO_OP_POP: begin
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                    count_r  <= count_r - 4'd1;
                end
                FIFO_OP_BOTH: begin
                    wr_ptr_r <= ptr_next(wr_ptr_r);
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                end
                default: begin
                    wr_ptr_r <= wr_ptr_r;
                    rd_ptr_r <= rd_ptr_r;
                    count_r  <= count_r;
                end
            endcase
        end
    end

    // Entry write; suppressed whenever reset or flush discards the push.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: doc/fifo8x64.md
FIFO8X64 -- requirements
Module: fifo8x64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits; only 64 is supported.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; only 8 is supported, giving 3-bit pointers.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all entries.
REQ-006 SHALL have port in_valid, input, 1, producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1, FIFO accepts a push this cycle.
REQ-008 SHALL have port in_data, input, 64, push data.
REQ-009 SHALL have port out_valid, output, 1, out_data holds the head entry.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the head this cycle.
REQ-011 SHALL have port out_data, output, 64, head entry data.
REQ-012 SHALL have port count, output, 4, occupancy 0..8.

Function
REQ-013 SHALL push on a cycle where in_valid and in_ready are both 1: write in_data to entry wr_ptr, then wr_ptr increments.
REQ-014 SHALL pop on a cycle where out_valid and out_ready are both 1: rd_ptr increments.
REQ-015 SHALL wrap each pointer from 7 to 0.
REQ-016 SHALL drive in_ready = (count != 8), combinationally from registered state; a full FIFO takes no push even if a pop happens in the same cycle.
REQ-017 SHALL drive out_valid = (count != 0) and out_data = entry[rd_ptr], combinationally, first-word-fall-through, 0 cycles from state to output.
REQ-018 SHALL drive out_data = 0 while out_valid is 0.
REQ-019 SHALL update count +1 on push only, -1 on pop only, unchanged on push and pop together; count never exceeds 8 or goes below 0.
REQ-020 SHALL make a pushed entry visible on out_data the cycle after the push when the FIFO was empty (latency 1 without the REQ-027 option).
REQ-021 SHALL give flush priority over push and pop: wr_ptr, rd_ptr and count go to 0 the next cycle, and any push or pop in that cycle is dropped.
REQ-022 SHALL ignore out_ready when empty and in_valid when full, with no state change.
REQ-023 SHALL keep in_valid/in_data and out_ready independent; neither handshake waits on the other side.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0 and count=0, giving in_ready=1, out_valid=0, out_data=0 and count=0 the next cycle.
REQ-025 SHALL let rst override flush, push and pop, including reset asserted mid-stream with a full FIFO.
REQ-026 SHALL leave the storage array unreset; REQ-018 masks stale contents.

Configuration
REQ-027 SHALL compile an empty-bypass path when macro FIFO8X64_BYPASS_EN is defined: while count==0 and in_valid=1, out_valid=1 and out_data=in_data in the same cycle; if out_ready=1 that cycle the word passes through, no write occurs and count stays 0; if out_ready=0 it is written as a normal push.
REQ-028 SHALL, without FIFO8X64_BYPASS_EN, behave exactly as REQ-017 to REQ-020, with out_valid depending only on registered state.

Structure
REQ-029 SHALL place FIFO_DEPTH=8, FIFO_WIDTH=64, FIFO_PTR_W=3 and FIFO_CNT_W=4 in shared package fifo_pkg.
REQ-030 SHALL build the head-select datapath as one sub-module instance of the codebase's 8:1 64-bit keyed selector mux81, keyed by rd_ptr with default 0.
REQ-031 SHALL keep all pointer, count and storage registers in fifo8x64 itself.

Verification
REQ-032 SHALL check reset: assert rst for 2 cycles with prior content -> count=0, in_ready=1, out_valid=0, out_data=0.
REQ-033 SHALL check fill and drain: push 0x1111_0000_0000_0001 through 0x...0008 with out_ready=0 -> count=8 and in_ready=0; a 9th push is refused; then drain with out_ready=1 -> data out in order, count ends at 0.
REQ-034 SHALL check wrap: push 5, pop 5, push 6 -> wr_ptr wraps to 3, and the 6 values pop in order with correct data across entry 7->0.
REQ-035 SHALL check simultaneous push and pop at count=4 for 10 cycles -> count stays 4 and the output stream is the input stream delayed by 4 entries.
REQ-036 SHALL check flush at count=5 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed word never appears.
REQ-037 SHALL check bypass with FIFO8X64_BYPASS_EN: empty FIFO, in_valid=1, in_data=0xDEAD_BEEF_0000_00AA, out_ready=1 -> out_data=0xDEAD_BEEF_0000_00AA in the same cycle and count stays 0; without the macro, out_valid stays 0 that cycle and the word appears the next cycle.
